// File: rtl/carry_select_subtractor_seq.sv
// carry_select_subtractor_seq: multi-cycle a - b - bin, one BLOCK-bit borrow-select slice per clock.
// Optional signed overflow flag enabled by defining SUB_OVERFLOW_EN.
module carry_select_subtractor_seq #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             bout
);
  localparam int NB = WIDTH / BLOCK;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0] cnt;
  logic brw;
  logic [BLOCK-1:0] a_k, b_k;
  logic [BLOCK:0] r0, r1, sel;
  assign in_ready = (state == IDLE);
  assign a_k = a_r[cnt*BLOCK +: BLOCK];
  assign b_k = b_r[cnt*BLOCK +: BLOCK];
  // both slice outcomes are formed up front; the bit above the slice is its borrow
  assign r0 = {1'b0, a_k} - {1'b0, b_k};
  assign r1 = {1'b0, a_k} - {1'b0, b_k} - 1'b1;
  assign sel = brw ? r1 : r0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      brw       <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= RUN;
          a_r   <= a;
          b_r   <= b;
          brw   <= bin;
          cnt   <= '0;
          diff  <= '0;
        end
        RUN: begin
          diff[cnt*BLOCK +: BLOCK] <= sel[BLOCK-1:0];
          brw <= sel[BLOCK];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            bout      <= sel[BLOCK];
            out_valid <= 1'b1;
`ifdef SUB_OVERFLOW_EN
            ovf <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sel[BLOCK-1] != a_r[WIDTH-1]);
`endif
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
